sent_tx_frame_builder: RTL and testbench
========================================

# sent_tx_frame_builder

Downstream stage of the SENT transmit data register. It captures the assembled fast-channel words `data_f1` and `data_f2` on their `done_f1` and `done_f2` strobes. It then packs them into six data nibbles per the selected fast-channel format, computes the SENT CRC-4 serially one nibble per clock, and hands a complete 8-nibble frame (status, D1..D6, CRC) to the pulse generator over a valid/ready handshake.

## Interface
Parameters:
- `CRC_SEED`, default 4'b0101: CRC-4 initial value.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `fmt`  in  2  format select.
  - 00: 12-bit F1 / 12-bit F2.
  - 01: 14-bit F1 / 10-bit F2.
  - 10: 16-bit F1 / 8-bit F2.
  - 11: reserved, treated as 00.
- `data_f1`  in  16  fast-channel-1 word, right-justified.
- `data_f2`  in  12  fast-channel-2 word, right-justified.
- `done_f1`  in  1  one-cycle strobe; `data_f1` is valid in this cycle.
- `done_f2`  in  1  one-cycle strobe; `data_f2` is valid in this cycle.
- `status_nibble`  in  4  status/communication nibble, sampled at frame load.
- `frame_valid`  out  1  frame available to the pulse generator.
- `frame_ready`  in  1  pulse generator accepts the frame.
- `frame_nibbles`  out  32  {status, D1, D2, D3, D4, D5, D6, CRC}; status sits in [31:28].
- `busy`  out  1  FSM is not in IDLE.
- `overrun_f1`  out  1  one-cycle pulse: `done_f1` arrived while the F1 holding register was still full.
- `overrun_f2`  out  1  one-cycle pulse: `done_f2` arrived while the F2 holding register was still full.

## Operation
Holding registers:
- `done_fx` loads `data_fx` into `hold_fx` and sets `hold_fx_valid`.
- If `hold_fx_valid` is already set and is not being consumed in the same cycle: the new data overwrites the old and `overrun_fx` pulses.
- If `done_fx` coincides with consumption: the new data is captured, valid stays 1, and no overrun is flagged.

Payload, a 24-bit value:
- fmt 00: {hold_f1[11:0], hold_f2[11:0]}.
- fmt 01: {hold_f1[13:0], hold_f2[9:0]}.
- fmt 10: {hold_f1[15:0], hold_f2[7:0]}.
- Dk = payload[27-4k -: 4], so D1 = payload[23:20] and D6 = payload[3:0].

FSM states:
- IDLE: when `hold_f1_valid` and `hold_f2_valid` are both set:
  - latch the payload, `fmt`-derived nibbles and `status_nibble`;
  - clear both valids;
  - set crc = `CRC_SEED` and cnt = 0;
  - go to CALC.
- CALC: each cycle apply crc_step to nibble D(cnt+1), then cnt++.
  - After D6, go to AUG when the macro is defined, otherwise go to PRESENT.
- AUG: apply crc_step(crc, 4'h0), then go to PRESENT.
- PRESENT: `frame_valid` = 1 and `frame_nibbles` is held stable. On `frame_valid` & `frame_ready`, go to IDLE.

crc_step(c, d):
- Process bits d[3] down to d[0] in that order.
- For each bit: fb = c[3] ^ bit; c = {c[2:0], 1'b0} ^ (fb ? 4'hD : 4'h0).
- The polynomial is x^4+x^3+x^2+1.
- The status nibble is excluded from the CRC.

Other rules:
- `fmt` is sampled only at IDLE→CALC; changing it mid-frame has no effect on the frame in flight.
- `frame_ready` while not in PRESENT is ignored.
- Reset mid-operation: return to IDLE, discard the frame and the holding registers.

## Timing
Reset values:
- `frame_valid`, `busy`, `overrun_f1`, `overrun_f2` = 0.
- `frame_nibbles` = 0.
- Holding registers, valids, crc and cnt = 0; FSM in IDLE.

Latency, with E0 = the rising edge on which the later of `done_f1`/`done_f2` is sampled:
- E1: IDLE→CALC.
- E2..E7: nibble steps.
- `frame_valid` is high after E7 without the macro, or after E8 with it.
- That is, 7 or 8 cycles from E0.

Handshake and throughput:
- The transfer occurs on the rising edge where `frame_valid` & `frame_ready` are both high.
- `frame_valid` is low the following cycle.
- The minimum gap between frames is one IDLE cycle.
- `frame_ready` may be held high permanently.
- `busy` is high in CALC, AUG and PRESENT.

## Configuration
- `SENT_CRC_AUGMENT_EN` defined: the AUG state is compiled in. One zero nibble is appended to the CRC (recommended method). Latency is 8 cycles.
- `SENT_CRC_AUGMENT_EN` undefined: there is no AUG state and the CRC covers D1..D6 only (legacy method). Latency is 7 cycles.

## Test plan
- Reset, fmt 00, `data_f1` = 0, `data_f2` = 0, both done strobes, `status_nibble` = 4'h0, `frame_ready` = 1. Required response:
  - `frame_nibbles` = 32'h0000_000F without the macro;
  - `frame_nibbles` = 32'h0000_0005 with the macro;
  - `frame_valid` asserts exactly 7 or 8 cycles after E0 respectively.
- fmt 01, `data_f1` = 16'h2ABC, `data_f2` = 12'h3F5, `status_nibble` = 4'h9. Required: nibbles 9,A,A,F,3,F,5; the CRC matches the crc_step reference model.
- fmt 10, `data_f1` = 16'h1234, `data_f2` = 12'hF56. Required: D1..D6 = 1,2,3,4,5,6; F2 bits [11:8] are ignored.
- `frame_ready` = 0 for 10 cycles in PRESENT with new done strobes arriving. Required: `frame_nibbles` is stable, the new data is held, and a second frame follows one IDLE cycle after acceptance.
- `done_f1` twice before any `done_f2`. Required: `overrun_f1` pulses once and the frame carries the second `data_f1`. A `done_f2` coinciding with the IDLE→CALC consumption gives no overrun.
- Assert `reset` during CALC. Required: all outputs return to 0 immediately, and no frame is emitted until new strobes on both channels.

Source files
------------

// File: rtl/sent_tx_frame_builder.sv
// sent_tx_frame_builder
// Captures the two fast-channel words and packs them into six data nibbles
// according to fmt. The CRC-4 is computed serially, one nibble per clock, and
// the finished 8-nibble SENT frame is presented over a valid/ready handshake.
// Optional build macro: SENT_CRC_AUGMENT_EN. When it is defined, one zero
// nibble is appended to the CRC (recommended method). When it is undefined,
// the CRC covers D1..D6 only (legacy method).

module sent_tx_frame_builder #(
    parameter logic [3:0] CRC_SEED = 4'b0101
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  fmt,
    input  logic [15:0] data_f1,
    input  logic [11:0] data_f2,
    input  logic        done_f1,
    input  logic        done_f2,
    input  logic [3:0]  status_nibble,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic [31:0] frame_nibbles,
    output logic        busy,
    output logic        overrun_f1,
    output logic        overrun_f2
);

`ifdef SENT_CRC_AUGMENT_EN
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CALC    = 2'd1,
        S_PRESENT = 2'd2,
        S_AUG     = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CALC    = 2'd1,
        S_PRESENT = 2'd2
    } state_t;
`endif

    state_t      state, state_next;

    logic [15:0] hold_f1;
    logic [11:0] hold_f2;
    logic        hold_f1_valid, hold_f2_valid;

    logic [23:0] payload_in;    // payload packed from the holding registers
    logic [23:0] payload_r;     // payload of the frame in flight
    logic [23:0] shift_r;       // D1 sits in [23:20]; shifts left once per CALC step
    logic [3:0]  status_r;
    logic [3:0]  crc, crc_next;
    logic [2:0]  cnt;
    logic        consume;       // IDLE takes both holding registers this cycle
    logic        load_frame;    // final CRC is ready; publish the frame

    // Serial CRC-4 over one nibble, MSB first, polynomial x^4+x^3+x^2+1
    function automatic logic [3:0] crc_step(input logic [3:0] c, input logic [3:0] d);
        logic [3:0] r;
        logic       fb;
        r = c;
        for (int i = 3; i >= 0; i--) begin
            fb = r[3] ^ d[i];
            r  = {r[2:0], 1'b0} ^ (fb ? 4'hD : 4'h0);
        end
        return r;
    endfunction

    // Pack the held words per the format; the reserved code 11 behaves like 00
    always_comb begin
        case (fmt)
            2'b01:   payload_in = {hold_f1[13:0], hold_f2[9:0]};
            2'b10:   payload_in = {hold_f1[15:0], hold_f2[7:0]};
            default: payload_in = {hold_f1[11:0], hold_f2[11:0]};
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic, per-state CRC step, and frame publish strobe
    always_comb begin
        state_next = state;
        consume    = 1'b0;
        crc_next   = crc;
        load_frame = 1'b0;
        case (state)
            S_IDLE: begin
                if (hold_f1_valid && hold_f2_valid) begin
                    consume    = 1'b1;
                    state_next = S_CALC;
                end
            end
            S_CALC: begin
                crc_next = crc_step(crc, shift_r[23:20]);
                if (cnt == 3'd5) begin
`ifdef SENT_CRC_AUGMENT_EN
                    state_next = S_AUG;
`else
                    state_next = S_PRESENT;
                    load_frame = 1'b1;
`endif
                end
            end
`ifdef SENT_CRC_AUGMENT_EN
            S_AUG: begin
                crc_next   = crc_step(crc, 4'h0);
                state_next = S_PRESENT;
                load_frame = 1'b1;
            end
`endif
            S_PRESENT: begin
                if (frame_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign frame_valid = (state == S_PRESENT);
    assign busy        = (state != S_IDLE);

    // Holding registers: a new strobe always wins; overrun only if the old word was never taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_f1       <= '0;
            hold_f2       <= '0;
            hold_f1_valid <= 1'b0;
            hold_f2_valid <= 1'b0;
            overrun_f1    <= 1'b0;
            overrun_f2    <= 1'b0;
        end else begin
            overrun_f1 <= done_f1 && hold_f1_valid && !consume;
            overrun_f2 <= done_f2 && hold_f2_valid && !consume;
            if (done_f1) begin
                hold_f1       <= data_f1;
                hold_f1_valid <= 1'b1;
            end else if (consume) begin
                hold_f1_valid <= 1'b0;
            end
            if (done_f2) begin
                hold_f2       <= data_f2;
                hold_f2_valid <= 1'b1;
            end else if (consume) begin
                hold_f2_valid <= 1'b0;
            end
        end
    end

    // Frame datapath: latch at load, step the CRC, publish when the last step completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            payload_r     <= '0;
            shift_r       <= '0;
            status_r      <= '0;
            crc           <= '0;
            cnt           <= '0;
            frame_nibbles <= '0;
        end else begin
            if (consume) begin
                payload_r <= payload_in;
                shift_r   <= payload_in;
                status_r  <= status_nibble;
                crc       <= CRC_SEED;
                cnt       <= 3'd0;
            end else begin
                crc <= crc_next;
                if (state == S_CALC) begin
                    shift_r <= {shift_r[19:0], 4'h0};
                    cnt     <= cnt + 3'd1;
                end
            end
            if (load_frame) frame_nibbles <= {status_r, payload_r, crc_next};
        end
    end

endmodule

// File: tb/tb_sent_tx_frame_builder.sv
// Directed bench for sent_tx_frame_builder. The expected frames are worked
// out by hand from the CRC definition. It builds with or without
// SENT_CRC_AUGMENT_EN.

module tb_sent_tx_frame_builder;

`ifdef SENT_CRC_AUGMENT_EN
    localparam int          LAT   = 8;
    localparam logic [31:0] T1EXP = 32'h0000_0005;
    localparam logic [31:0] T2EXP = 32'h9AAF_3F59;
    localparam logic [31:0] T3EXP = 32'h3123_4561;
`else
    localparam int          LAT   = 7;
    localparam logic [31:0] T1EXP = 32'h0000_000F;
    localparam logic [31:0] T2EXP = 32'h9AAF_3F56;
    localparam logic [31:0] T3EXP = 32'h3123_4568;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  fmt;
    logic [15:0] data_f1;
    logic [11:0] data_f2;
    logic        done_f1, done_f2;
    logic [3:0]  status_nibble;
    logic        frame_valid, frame_ready;
    logic [31:0] frame_nibbles;
    logic        busy, overrun_f1, overrun_f2;

    int checks   = 0;
    int failures = 0;

    sent_tx_frame_builder dut (
        .clk           (clk),
        .reset         (reset),
        .fmt           (fmt),
        .data_f1       (data_f1),
        .data_f2       (data_f2),
        .done_f1       (done_f1),
        .done_f2       (done_f2),
        .status_nibble (status_nibble),
        .frame_valid   (frame_valid),
        .frame_ready   (frame_ready),
        .frame_nibbles (frame_nibbles),
        .busy          (busy),
        .overrun_f1    (overrun_f1),
        .overrun_f2    (overrun_f2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge: drive strobes for one rising edge, return at the next negedge
    task automatic strobe(input logic d1, input logic d2, input logic [15:0] v1, input logic [11:0] v2);
        done_f1 = d1;
        done_f2 = d2;
        if (d1) data_f1 = v1;
        if (d2) data_f2 = v2;
        @(negedge clk);
        done_f1 = 1'b0;
        done_f2 = 1'b0;
    endtask

    // Count negedges until frame_valid is seen (bounded)
    task automatic wait_valid(output int n);
        n = 0;
        while (!frame_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int seen;
        reset         = 1'b1;
        fmt           = 2'b00;
        data_f1       = '0;
        data_f2       = '0;
        done_f1       = 1'b0;
        done_f2       = 1'b0;
        status_nibble = 4'h0;
        frame_ready   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", frame_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_frame", frame_nibbles, 0);
        check("rst_ov1", overrun_f1, 0);
        check("rst_ov2", overrun_f2, 0);
        reset = 1'b0;
        @(negedge clk);

        // All-zero frame, ready held high
        frame_ready = 1'b1;
        strobe(1'b1, 1'b1, 16'h0000, 12'h000);
        check("t1_idle_at_e0", busy, 0);
        wait_valid(n);
        check("t1_latency", n, LAT);
        check("t1_frame", frame_nibbles, T1EXP);
        @(negedge clk);
        check("t1_valid_drop", frame_valid, 0);
        check("t1_busy_drop", busy, 0);

        // fmt 10 frame; fmt changes mid-frame; then a 10-cycle stall with new strobes
        frame_ready   = 1'b0;
        fmt           = 2'b10;
        status_nibble = 4'h3;
        strobe(1'b1, 1'b1, 16'h1234, 12'hF56);
        @(negedge clk);
        check("t3_busy_calc", busy, 1);
        fmt = 2'b01;
        wait_valid(n);
        check("t3_latency", n, LAT - 1);
        check("t3_frame", frame_nibbles, T3EXP);
        status_nibble = 4'h9;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin done_f1 = 1'b1; data_f1 = 16'h2ABC; end
            if (i == 3) data_f1 = 16'hFFFF;
            if (i == 5) begin done_f2 = 1'b1; data_f2 = 12'h3F5; end
            if (i == 6) data_f2 = 12'h000;
            @(negedge clk);
            done_f1 = 1'b0;
            done_f2 = 1'b0;
            check("stall_valid", frame_valid, 1);
            check("stall_stable", frame_nibbles, T3EXP);
        end
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        check("accept_valid_drop", frame_valid, 0);
        wait_valid(n);
        check("t2_gap_latency", n, LAT);
        check("t2_frame", frame_nibbles, T2EXP);
        frame_ready = 1'b1;
        @(negedge clk);

        // Overrun on F1, coincident F2 strobe at consumption
        fmt           = 2'b00;
        status_nibble = 4'hC;
        strobe(1'b1, 1'b0, 16'h0111, 12'h000);
        check("ov1_first", overrun_f1, 0);
        strobe(1'b1, 1'b0, 16'h0ABC, 12'h000);
        check("ov1_pulse", overrun_f1, 1);
        @(negedge clk);
        check("ov1_one_cycle", overrun_f1, 0);
        strobe(1'b0, 1'b1, 16'h0000, 12'h456);
        check("ov2_first", overrun_f2, 0);
        strobe(1'b0, 1'b1, 16'h0000, 12'h789);
        check("ov2_coincide", overrun_f2, 0);
        check("ov_busy", busy, 1);
        wait_valid(n);
        check("ov_latency", n, LAT - 1);
        check("ov_frame", frame_nibbles[31:4], 28'hCABC456);
        strobe(1'b1, 1'b0, 16'h0DEF, 12'h000);
        wait_valid(n);
        check("kept_f2_latency", n, LAT);
        check("kept_f2_frame", frame_nibbles[31:4], 28'hCDEF789);
        @(negedge clk);

        // Reset during CALC
        strobe(1'b1, 1'b1, 16'h0AAA, 12'h555);
        @(negedge clk);
        @(negedge clk);
        check("mid_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", frame_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_frame", frame_nibbles, 0);
        check("mid_rst_ov", {overrun_f1, overrun_f2}, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (frame_valid || busy) seen = 1;
        end
        check("post_rst_quiet", seen, 0);
        strobe(1'b1, 1'b0, 16'h0321, 12'h000);
        @(negedge clk);
        @(negedge clk);
        check("post_rst_f1_only", busy, 0);
        strobe(1'b0, 1'b1, 16'h0000, 12'h654);
        wait_valid(n);
        check("post_rst_latency", n, LAT);
        check("post_rst_frame", frame_nibbles[31:4], 28'hC321654);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
